// File: rtl/baud_tick_gen.sv
// Free-running baud-rate tick generator: divides clk by BAUD_COUNT and emits a
// registered single-cycle baud_tick strobe once per baud period.
`timescale 1ns/1ps

module baud_tick_gen #(
    parameter int SYS_CLK    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int BAUD_COUNT = SYS_CLK / BAUD
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick
);

    localparam int unsigned CW = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_COUNT - 1);

    if (BAUD_COUNT < 1) begin : g_bad_count
        $error("baud_tick_gen: BAUD_COUNT must be >= 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;
    logic          wrap_c;

    // Terminal count: wrap to zero and raise the strobe for the next cycle.
    always_comb begin
        wrap_c = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (wrap_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign baud_tick = tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: four instances (10, 1, 2, default count) on a shared
// clock/reset, checked against an edges-since-release model plus directed checks.
`timescale 1ns/1ps

module tb_baud_tick_gen;

    localparam int BC_A   = 10;
    localparam int BC_DEF = 100_000_000 / 9600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_a;
    logic tick_1;
    logic tick_2;
    logic tick_d;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned n_edges;

    baud_tick_gen #(.BAUD_COUNT(BC_A)) u_dut_a (.clk(clk), .rst(rst), .baud_tick(tick_a));
    baud_tick_gen #(.BAUD_COUNT(1))    u_dut_1 (.clk(clk), .rst(rst), .baud_tick(tick_1));
    baud_tick_gen #(.BAUD_COUNT(2))    u_dut_2 (.clk(clk), .rst(rst), .baud_tick(tick_2));
    baud_tick_gen                      u_dut_d (.clk(clk), .rst(rst), .baud_tick(tick_d));

    always #1 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tick is high right after every multiple-of-BC edge since reset release.
    function automatic logic model_tick(input int unsigned n, input int bc);
        return (n >= 1) && ((n % bc) == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    always @(negedge clk) begin
        check_bit("model_a",   tick_a, rst ? 1'b0 : model_tick(n_edges, BC_A));
        check_bit("model_1",   tick_1, rst ? 1'b0 : model_tick(n_edges, 1));
        check_bit("model_2",   tick_2, rst ? 1'b0 : model_tick(n_edges, 2));
        check_bit("model_def", tick_d, rst ? 1'b0 : model_tick(n_edges, BC_DEF));
    end

    initial begin
        int cnt;
        int last;
        int w;
        logic seen;

        // Reset held: every instance quiet even after a clock edge.
        #1.5;
        check_bit("rst_a", tick_a, 1'b0);
        check_bit("rst_1", tick_1, 1'b0);
        check_bit("rst_2", tick_2, 1'b0);
        check_bit("rst_d", tick_d, 1'b0);
        #3 rst = 1'b0;

        // First-tick latency and single-cycle width.
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #0.5;
            check_bit("first_a", tick_a, k == 10);
            check_bit("first_1", tick_1, 1'b1);
            check_bit("first_2", tick_2, (k % 2) == 0);
        end

        // 1000 cycles: 100 ticks, each 10 cycles apart.
        cnt  = 0;
        last = -1;
        for (int k = 12; k <= 1011; k++) begin
            @(posedge clk); #0.5;
            if (tick_a) begin
                cnt++;
                if (last >= 0) check_int("spacing_a", k - last, 10);
                last = k;
            end
        end
        check_int("count_1000", cnt, 100);

        // Reset at count 5 mid-period: next tick 10 edges after release.
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #0.5;
            seen = tick_a;
        end
        check_bit("sync_tick_a", seen, 1'b1);
        repeat (5) @(posedge clk);
        #0.5 rst = 1'b1;
        #0.2 check_bit("mid_rst_a", tick_a, 1'b0);
        #0.8 rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #0.5;
            check_bit("after_mid_a", tick_a, k == 10);
        end

        // Reset while tick high: falls without a clock edge.
        #0.1 rst = 1'b1;
        #0.1;
        check_bit("cut_a", tick_a, 1'b0);
        check_bit("cut_1", tick_1, 1'b0);
        #0.8 rst = 1'b0;

        // Default count: 10416 cycles to first tick, then 5 spacings of 10416.
        for (int t = 0; t < 6; t++) begin
            w    = 0;
            seen = 1'b0;
            while (!seen && w < 11000) begin
                @(posedge clk); #0.5;
                w++;
                seen = tick_d;
            end
            check_int("spacing_def", w, 10416);
            if (!seen) break;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
